// File: rtl/cpu_clk_pkg.sv
// Shared mode encoding for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT     = 2'b00,
    MODE_RUN_DIV  = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_RUN_FULL = 2'b11
  } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, level debouncer and rising-edge detect.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          level_r;
  logic          level_nxt_s;
  logic          level_d_r;

  // Debounce counter and level update.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    if (sync_r[1] == level_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == LAST_CNT) begin
      level_nxt_s = sync_r[1];
      cnt_nxt_s   = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1'b1);
    end
  end

  // Synchroniser, counter, level and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r    <= 2'b00;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
    end else begin
      sync_r    <= {sync_r[0], raw};
      cnt_r     <= cnt_nxt_s;
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_d_r;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: halt, divided run, full-speed run and debounced single-step.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           i_mode,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_step_btn,
  output logic                 o_cpu_en,
  output logic [CNT_WIDTH-1:0] o_tick_cnt,
  output logic                 o_heartbeat,
  output logic                 o_btn_level
);

  mode_t                mode_s;
  logic                 step_req_s;
  logic                 fire_s;
  logic [DIV_WIDTH-1:0] div_cnt_r;
  logic [DIV_WIDTH-1:0] div_nxt_s;
  logic                 cpu_en_r;
  logic [CNT_WIDTH-1:0] tick_cnt_r;
  logic                 heartbeat_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (i_step_btn),
    .level  (o_btn_level),
    .rise   (step_req_s)
  );

  assign mode_s = mode_t'(i_mode);

  // Mode mux: divider next state and fire decision.
  // ">=" lets a lowered i_div fire on the next cycle instead of wrapping the counter.
  always_comb begin
    fire_s    = 1'b0;
    div_nxt_s = '0;
    case (mode_s)
      MODE_RUN_DIV: begin
        if (div_cnt_r >= i_div) begin
          fire_s    = 1'b1;
          div_nxt_s = '0;
        end else begin
          fire_s    = 1'b0;
          div_nxt_s = div_cnt_r + DIV_WIDTH'(1'b1);
        end
      end
      MODE_RUN_FULL: fire_s = 1'b1;
      MODE_STEP:     fire_s = step_req_s;
      MODE_HALT:     fire_s = 1'b0;
      default:       fire_s = 1'b0;
    endcase
  end

  // Divider and registered enable, pulse counter and heartbeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r   <= '0;
      cpu_en_r    <= 1'b0;
      tick_cnt_r  <= '0;
      heartbeat_r <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      cpu_en_r  <= fire_s;
      if (fire_s) begin
        tick_cnt_r  <= tick_cnt_r + CNT_WIDTH'(1'b1);
        heartbeat_r <= ~heartbeat_r;
      end
    end
  end

  assign o_cpu_en    = cpu_en_r;
  assign o_tick_cnt  = tick_cnt_r;
  assign o_heartbeat = heartbeat_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl with a short debounce window.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int DW = 24;
  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic          btn;
  logic          cpu_en;
  logic [CW-1:0] tick;
  logic          hb;
  logic          lvl;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] exp_tick;
  logic          exp_hb;
  logic [7:0]    bounce_pat;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_WIDTH      (DW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_mode     (mode),
    .i_div      (div),
    .i_step_btn (btn),
    .o_cpu_en   (cpu_en),
    .o_tick_cnt (tick),
    .o_heartbeat(hb),
    .o_btn_level(lvl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock, then compare the enable and advance the expected counters.
  task automatic expect_cycle(input string tag, input logic exp_en);
    cyc();
    check(tag, 32'(cpu_en), 32'(exp_en));
    if (exp_en) begin
      exp_tick = exp_tick + 8'd1;
      exp_hb   = ~exp_hb;
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_lvl);
    check({tag, "_tick"}, 32'(tick), 32'(exp_tick));
    check({tag, "_hb"},   32'(hb),   32'(exp_hb));
    check({tag, "_lvl"},  32'(lvl),  32'(exp_lvl));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    mode       = MODE_HALT;
    div        = '0;
    btn        = 1'b0;
    exp_tick   = 8'd0;
    exp_hb     = 1'b0;
    bounce_pat = 8'b0011_0011;
    repeat (3) cyc();
    check("reset_en", 32'(cpu_en), 32'd0);
    check_outs("reset", 1'b0);
    reset_n = 1'b1;
    cyc();

    // RUN_DIV, i_div=3: pulse on every 4th edge
    mode = MODE_RUN_DIV;
    div  = 24'd3;
    for (int k = 1; k <= 20; k++) expect_cycle("rundiv3_en", (k % 4) == 0);
    check("rundiv3_tick", 32'(tick), 32'd5);
    check("rundiv3_hb",   32'(hb),   32'd1);
    mode = MODE_HALT;
    expect_cycle("rundiv3_exit", 1'b0);

    // RUN_DIV, i_div=0: enable every cycle
    mode = MODE_RUN_DIV;
    div  = 24'd0;
    for (int k = 0; k < 5; k++) expect_cycle("rundiv0_en", 1'b1);
    mode = MODE_HALT;
    expect_cycle("rundiv0_exit", 1'b0);
    check_outs("rundiv0", 1'b0);

    // i_div lowered 10 -> 2 with div_cnt at 7
    mode = MODE_RUN_DIV;
    div  = 24'd10;
    for (int k = 0; k < 7; k++) expect_cycle("divchg_pre", 1'b0);
    div = 24'd2;
    expect_cycle("divchg_first", 1'b1);
    for (int k = 1; k <= 6; k++) expect_cycle("divchg_period", (k % 3) == 0);
    mode = MODE_HALT;
    expect_cycle("divchg_exit", 1'b0);

    // Clean step press: one pulse 7 edges after the input edge, none on release
    mode = MODE_STEP;
    btn  = 1'b1;
    for (int k = 1; k <= 10; k++) expect_cycle("step_press", k == 7);
    check_outs("step_held", 1'b1);
    btn = 1'b0;
    for (int k = 0; k < 10; k++) expect_cycle("step_release", 1'b0);
    check_outs("step_rel", 1'b0);

    // Bounced press 1-1-0-0-1-1-0-0 then stable high
    for (int k = 0; k < 20; k++) begin
      btn = (k < 8) ? bounce_pat[k] : 1'b1;
      expect_cycle("bounce_en", k == 14);
    end
    check_outs("bounce", 1'b1);
    btn = 1'b0;
    for (int k = 0; k < 8; k++) expect_cycle("bounce_release", 1'b0);

    // Three-cycle glitch only
    for (int k = 0; k < 10; k++) begin
      btn = (k < 3);
      expect_cycle("glitch_en", 1'b0);
      check("glitch_lvl", 32'(lvl), 32'd0);
    end

    // Presses in HALT are ignored
    mode = MODE_HALT;
    btn  = 1'b1;
    for (int k = 0; k < 10; k++) expect_cycle("halt_press", 1'b0);
    check("halt_lvl_high", 32'(lvl), 32'd1);
    btn = 1'b0;
    for (int k = 0; k < 10; k++) expect_cycle("halt_release", 1'b0);
    check_outs("halt", 1'b0);

    // RUN_FULL for 256 cycles, tick wraps through 0, then HALT
    mode = MODE_RUN_FULL;
    for (int k = 0; k < 256; k++) begin
      expect_cycle("full_en", 1'b1);
      if (exp_tick == 8'd0) check("full_wrap", 32'(tick), 32'd0);
    end
    mode = MODE_HALT;
    expect_cycle("full_exit", 1'b0);
    check_outs("full", 1'b0);

    // Reset mid-count and mid-debounce
    mode = MODE_RUN_DIV;
    div  = 24'd5;
    btn  = 1'b1;
    for (int k = 1; k <= 8; k++) expect_cycle("prerst_a", k == 6);
    btn = 1'b0;
    for (int k = 9; k <= 12; k++) expect_cycle("prerst_b", k == 12);
    check("prerst_lvl", 32'(lvl), 32'd1);
    reset_n = 1'b0;
    #2;
    check("rst_async_en", 32'(cpu_en), 32'd0);
    check("rst_async_tick", 32'(tick), 32'd0);
    check("rst_async_hb", 32'(hb), 32'd0);
    check("rst_async_lvl", 32'(lvl), 32'd0);
    exp_tick = 8'd0;
    exp_hb   = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) expect_cycle("postrst_en", k == 6);
    check_outs("postrst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
